// File: rtl/smg_pkg.sv
// smg_pkg: shared state/mode encoding and prescaler default for the MM:SS countdown timer.
package smg_pkg;
    localparam logic [3:0] MODE_IDLE    = 4'd0;
    localparam logic [3:0] MODE_SET_MIN = 4'd1;
    localparam logic [3:0] MODE_SET_SEC = 4'd2;
    localparam logic [3:0] MODE_RUN     = 4'd3;
    localparam logic [3:0] MODE_PAUSE   = 4'd4;
    localparam logic [3:0] MODE_DONE    = 4'd5;
    localparam logic [25:0] T1S_DEFAULT = 26'd49999999;
    // State codes double as the display mode nibble.
    typedef enum logic [3:0] {
        ST_IDLE    = MODE_IDLE,
        ST_SET_MIN = MODE_SET_MIN,
        ST_SET_SEC = MODE_SET_SEC,
        ST_RUN     = MODE_RUN,
        ST_PAUSE   = MODE_PAUSE,
        ST_DONE    = MODE_DONE
    } state_e;
endpackage

// File: rtl/smg_timer_module_if.sv
// smg_timer_module_if: key pulses in, BCD display word and alarm out.
interface smg_timer_module_if;
    logic [3:0]  key_value;
    logic [23:0] Num_output;
    logic        Alarm_Out;
    modport master (output key_value, input Num_output, input Alarm_Out);
    modport slave  (input key_value, output Num_output, output Alarm_Out);
endinterface

// File: rtl/bcd60_counter.sv
// bcd60_counter: two-digit mod-60 BCD counter with clear, increment (59->00) and decrement (00->59, borrow-out).
module bcd60_counter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       borrow
);
    logic [3:0] tens_d, tens_q, units_d, units_q;
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            units_d = (units_q == 4'd9) ? 4'd0 : units_q + 4'd1;
            tens_d  = (units_q != 4'd9) ? tens_q : (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
        end else if (dec) begin
            units_d = (units_q == 4'd0) ? 4'd9 : units_q - 4'd1;
            tens_d  = (units_q != 4'd0) ? tens_q : (tens_q == 4'd0) ? 4'd5 : tens_q - 4'd1;
        end
    end
    assign borrow = dec && !clr && !inc && tens_q == 4'd0 && units_q == 4'd0;
    assign tens   = tens_q;
    assign units  = units_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end
endmodule

// File: rtl/smg_timer_module.sv
// smg_timer_module: MM:SS countdown timer driving a BCD display word and an expiry alarm.
// Define SMG_TIMER_ALARM_EN to make Alarm_Out blink at half-second rate in DONE instead of holding high.
module smg_timer_module
    import smg_pkg::*;
#(
    parameter logic [25:0] T1S = T1S_DEFAULT
) (
    input  logic               CLK,
    input  logic               RSTn,
    smg_timer_module_if.slave  bus
);
    state_e      state_d, state_q;
    logic [25:0] prescaler_d, prescaler_q;
    logic        alarm_d, alarm_q;
    logic        k0, k1, k2, k3, tick, is_zero, to_zero, sec_borrow, min_borrow_unused;
    logic [3:0]  min_t, min_u, sec_t, sec_u;

    // One-hot the keys by priority: key3 > key0 > key1 > key2.
    assign k3 = bus.key_value[3];
    assign k0 = bus.key_value[0] && !k3;
    assign k1 = bus.key_value[1] && !k3 && !bus.key_value[0];
    assign k2 = bus.key_value[2] && !k3 && !bus.key_value[0] && !bus.key_value[1];

    assign is_zero = {min_t, min_u, sec_t, sec_u} == 16'h0000;
    assign tick    = state_q == ST_RUN && prescaler_q == T1S;
    assign to_zero = tick && !k3 && {min_t, min_u, sec_t, sec_u} == 16'h0001;

    bcd60_counter u_sec (
        .clk    (CLK),
        .rstn   (RSTn),
        .clr    (k3),
        .inc    (k2 && state_q == ST_SET_SEC),
        .dec    (tick),
        .tens   (sec_t),
        .units  (sec_u),
        .borrow (sec_borrow)
    );

    bcd60_counter u_min (
        .clk    (CLK),
        .rstn   (RSTn),
        .clr    (k3),
        .inc    (k2 && state_q == ST_SET_MIN),
        .dec    (sec_borrow),
        .tens   (min_t),
        .units  (min_u),
        .borrow (min_borrow_unused)
    );

    // Reaching 00:00 wins over a coincident pause so the timer never idles at zero in PAUSE.
    always_comb begin
        state_d = state_q;
        if (k3)
            state_d = ST_IDLE;
        else if (to_zero)
            state_d = ST_DONE;
        else if (k0)
            state_d = (state_q == ST_RUN)   ? ST_PAUSE :
                      (state_q == ST_PAUSE) ? ST_RUN   :
                      (state_q == ST_DONE)  ? ST_IDLE  :
                      is_zero               ? state_q  : ST_RUN;
        else if (k1)
            state_d = (state_q == ST_IDLE)    ? ST_SET_MIN :
                      (state_q == ST_SET_MIN) ? ST_SET_SEC :
                      (state_q == ST_SET_SEC) ? ST_IDLE    : state_q;
        prescaler_d = (state_d == ST_RUN || state_d == ST_PAUSE) ?
                      ((state_q == ST_RUN) ? (tick ? 26'd0 : prescaler_q + 26'd1) :
                       (state_q == ST_PAUSE) ? prescaler_q : 26'd0) : 26'd0;
    end

`ifdef SMG_TIMER_ALARM_EN
    localparam logic [25:0] HALF = T1S >> 1;
    logic [25:0] half_cnt_d, half_cnt_q;
    always_comb begin
        half_cnt_d = (state_d == ST_DONE && state_q == ST_DONE) ?
                     ((half_cnt_q == HALF) ? 26'd0 : half_cnt_q + 26'd1) : 26'd0;
        alarm_d    = (state_d != ST_DONE) ? 1'b0 :
                     (state_q != ST_DONE) ? 1'b1 :
                     (half_cnt_q == HALF) ? !alarm_q : alarm_q;
    end
`else
    always_comb alarm_d = state_d == ST_DONE;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            prescaler_q <= 26'd0;
            alarm_q     <= 1'b0;
`ifdef SMG_TIMER_ALARM_EN
            half_cnt_q  <= 26'd0;
`endif
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            alarm_q     <= alarm_d;
`ifdef SMG_TIMER_ALARM_EN
            half_cnt_q  <= half_cnt_d;
`endif
        end
    end

    assign bus.Num_output = {state_q, min_t, min_u, sec_t, sec_u, 4'd0};
    assign bus.Alarm_Out  = alarm_q;
endmodule
